// File: rtl/flag_shadow_restore_if.sv
// Bus between the control unit (master) and the C/Z flag shadow stack (slave).
// PAR_ERR exists only when FLAG_SHADOW_PARITY_EN is defined.
interface flag_shadow_restore_if #(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             C_IN;
   logic             Z_IN;
   logic             FLG_SHAD_LD;
   logic             FLG_RESTORE;
   logic             ERR_CLR;
   logic             C_RESTORE;
   logic             Z_RESTORE;
   logic             RESTORE_VLD;
   logic [CNT_W-1:0] COUNT;
   logic             EMPTY;
   logic             FULL;
   logic             OVF_ERR;
   logic             UNF_ERR;
`ifdef FLAG_SHADOW_PARITY_EN
   logic             PAR_ERR;
`endif

   modport master (
      output C_IN, Z_IN, FLG_SHAD_LD, FLG_RESTORE, ERR_CLR,
      input  C_RESTORE, Z_RESTORE, RESTORE_VLD, COUNT, EMPTY, FULL,
`ifdef FLAG_SHADOW_PARITY_EN
      input  PAR_ERR,
`endif
      input  OVF_ERR, UNF_ERR
   );

   modport slave (
      input  C_IN, Z_IN, FLG_SHAD_LD, FLG_RESTORE, ERR_CLR,
      output C_RESTORE, Z_RESTORE, RESTORE_VLD, COUNT, EMPTY, FULL,
`ifdef FLAG_SHADOW_PARITY_EN
      output PAR_ERR,
`endif
      output OVF_ERR, UNF_ERR
   );
endinterface

// File: rtl/flag_shadow_restore.sv
// Nested-interrupt C/Z flag shadow stack. Interrupt entry pushes the live
// {C,Z}; RETID/RETIE pops the top entry and presents it, registered, to the
// flag registers with a one-cycle RESTORE_VLD pulse. The stack pointer is the
// occupancy counter itself.
// Optional macro FLAG_SHADOW_PARITY_EN: per-entry even parity, checked on pop,
// reported on sticky PAR_ERR.
module flag_shadow_restore #(
   parameter int DEPTH = 4
) (
   input logic                clk,
   input logic                RST_N,
   flag_shadow_restore_if.slave bus
);
   localparam int               CNT_W    = $clog2(DEPTH) + 1;
   localparam int               IDX_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [1:0]       stack_cz [DEPTH];
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             pop_ok;
   logic             push_new;
   logic             replace;
   logic             wr_en;
   logic             ovf_set;
   logic             unf_set;
   logic [IDX_W-1:0] top_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             c_restore;
   logic             z_restore;
   logic             restore_vld;
   logic             ovf_err;
   logic             unf_err;
`ifdef FLAG_SHADOW_PARITY_EN
   logic             stack_par [DEPTH];
   logic             par_set;
   logic             par_err;
`endif

   // Strobe decode: classify the cycle as new push, top replace, pop, or error.
   always_comb begin
      push      = bus.FLG_SHAD_LD;
      pop       = bus.FLG_RESTORE;
      empty     = (count == '0);
      full      = (count == CNT_FULL);
      pop_ok    = pop & ~empty;
      // With a simultaneous pop, a push only grows the stack when nothing
      // could be popped; otherwise it overwrites the slot being popped.
      push_new  = push & (pop ? empty : ~full);
      replace   = push & pop_ok;
      wr_en     = push_new | replace;
      ovf_set   = push & ~pop & full;
      unf_set   = pop & empty;
      top_idx   = IDX_W'(count - 1'b1);
      wr_idx    = replace ? top_idx : IDX_W'(count);
      count_nxt = count;
      if (push_new) begin
         count_nxt = count + 1'b1;
      end else if (pop_ok && !push) begin
         count_nxt = count - 1'b1;
      end
`ifdef FLAG_SHADOW_PARITY_EN
      par_set   = pop_ok & (stack_par[top_idx] != ^stack_cz[top_idx]);
`endif
   end

   // Occupancy counter / stack pointer.
   always_ff @(posedge clk) begin
      if (!RST_N) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

   // Stack storage; contents are don't-care after reset so no reset term.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         stack_cz[wr_idx] <= {bus.C_IN, bus.Z_IN};
`ifdef FLAG_SHADOW_PARITY_EN
         stack_par[wr_idx] <= bus.C_IN ^ bus.Z_IN;
`endif
      end
   end

   // Registered restore path: data holds unless a successful pop occurs.
   always_ff @(posedge clk) begin
      if (!RST_N) begin
         c_restore   <= 1'b0;
         z_restore   <= 1'b0;
         restore_vld <= 1'b0;
      end else begin
         restore_vld <= pop_ok;
         if (pop_ok) begin
            {c_restore, z_restore} <= stack_cz[top_idx];
         end
      end
   end

   // Sticky error flags; a new error in the same cycle beats ERR_CLR.
   always_ff @(posedge clk) begin
      if (!RST_N) begin
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         if (ovf_set) begin
            ovf_err <= 1'b1;
         end else if (bus.ERR_CLR) begin
            ovf_err <= 1'b0;
         end
         if (unf_set) begin
            unf_err <= 1'b1;
         end else if (bus.ERR_CLR) begin
            unf_err <= 1'b0;
         end
      end
   end

`ifdef FLAG_SHADOW_PARITY_EN
   // Sticky parity error, set on the same edge that raises RESTORE_VLD.
   always_ff @(posedge clk) begin
      if (!RST_N) begin
         par_err <= 1'b0;
      end else if (par_set) begin
         par_err <= 1'b1;
      end else if (bus.ERR_CLR) begin
         par_err <= 1'b0;
      end
   end
`endif

   // Output drive.
   always_comb begin
      bus.C_RESTORE   = c_restore;
      bus.Z_RESTORE   = z_restore;
      bus.RESTORE_VLD = restore_vld;
      bus.COUNT       = count;
      bus.EMPTY       = empty;
      bus.FULL        = full;
      bus.OVF_ERR     = ovf_err;
      bus.UNF_ERR     = unf_err;
`ifdef FLAG_SHADOW_PARITY_EN
      bus.PAR_ERR     = par_err;
`endif
   end
endmodule

// File: tb/tb_flag_shadow_restore.sv
// Directed vector bench for flag_shadow_restore (DEPTH=4).
module tb_flag_shadow_restore;
   localparam int DEPTH = 4;

   typedef struct {
      logic       rst_n, c, z, ld, rs, clr;
      logic       ec, ez, ev;
      logic [2:0] ecnt;
      logic       eovf, eunf;
   } vec_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   vec_t tbl[$];

   flag_shadow_restore_if #(.DEPTH(DEPTH)) bus ();

   flag_shadow_restore #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic add(input logic rst_n_i, input logic c, input logic z, input logic ld,
                      input logic rs, input logic clr, input logic ec, input logic ez,
                      input logic ev, input int cnt, input logic ovf, input logic unf);
      vec_t v;
      v.rst_n = rst_n_i; v.c = c; v.z = z; v.ld = ld; v.rs = rs; v.clr = clr;
      v.ec = ec; v.ez = ez; v.ev = ev; v.ecnt = 3'(cnt); v.eovf = ovf; v.eunf = unf;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic r, input logic c, input logic z, input logic ld,
                        input logic rs, input logic clr);
      rst_n           = r;
      bus.C_IN        = c;
      bus.Z_IN        = z;
      bus.FLG_SHAD_LD = ld;
      bus.FLG_RESTORE = rs;
      bus.ERR_CLR     = clr;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // packed view: c z vld cnt[2:0] empty full ovf unf
   function automatic logic [31:0] pack_out();
      return {22'd0, bus.C_RESTORE, bus.Z_RESTORE, bus.RESTORE_VLD, bus.COUNT,
              bus.EMPTY, bus.FULL, bus.OVF_ERR, bus.UNF_ERR};
   endfunction

   initial begin
      int n;
      vectors     = 0;
      miscompares = 0;
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

      //   rst c z ld rs clr | c z vld cnt ovf unf
      add(0, 1,1, 1,1,0,  0,0,0, 0, 0,0);  // reset with strobes active
      add(0, 1,1, 1,1,1,  0,0,0, 0, 0,0);
      add(1, 1,0, 1,0,0,  0,0,0, 1, 0,0);  // push C=1,Z=0
      add(1, 0,0, 0,0,0,  0,0,0, 1, 0,0);
      add(1, 0,0, 0,1,0,  1,0,1, 0, 0,0);  // pop -> 10
      add(1, 0,0, 0,0,0,  1,0,0, 0, 0,0);  // vld drops, data holds
      add(1, 0,1, 1,0,0,  1,0,0, 1, 0,0);  // push 01
      add(1, 1,0, 1,0,0,  1,0,0, 2, 0,0);  // push 10
      add(1, 1,1, 1,0,0,  1,0,0, 3, 0,0);  // push 11
      add(1, 0,0, 1,0,0,  1,0,0, 4, 0,0);  // push 00 -> FULL
      add(1, 1,1, 1,0,0,  1,0,0, 4, 1,0);  // push at FULL -> OVF
      add(1, 0,0, 0,1,0,  0,0,1, 3, 1,0);  // pop 00
      add(1, 0,0, 0,1,0,  1,1,1, 2, 1,0);  // pop 11
      add(1, 0,0, 0,1,0,  1,0,1, 1, 1,0);  // pop 10
      add(1, 0,0, 0,1,0,  0,1,1, 0, 1,0);  // pop 01
      add(1, 0,0, 0,1,0,  0,1,0, 0, 1,1);  // pop at EMPTY -> UNF
      add(1, 0,0, 0,0,1,  0,1,0, 0, 0,0);  // ERR_CLR
      add(1, 1,0, 1,0,0,  0,1,0, 1, 0,0);  // push 10
      add(1, 1,1, 1,0,0,  0,1,0, 2, 0,0);  // push 11
      add(1, 0,0, 1,1,0,  1,1,1, 2, 0,0);  // push 00 + pop -> 11
      add(1, 0,0, 0,1,0,  0,0,1, 1, 0,0);  // pop -> 00
      add(1, 0,0, 0,1,0,  1,0,1, 0, 0,0);  // pop -> 10
      add(1, 1,1, 1,1,0,  1,0,0, 1, 0,1);  // push+pop at EMPTY
      add(1, 0,0, 0,1,1,  1,1,1, 0, 0,0);  // clr + good pop -> 11
      add(1, 0,0, 0,1,1,  1,1,0, 0, 0,1);  // clr + underflow: set wins
      add(1, 0,1, 1,0,0,  1,1,0, 1, 0,1);
      add(1, 0,1, 1,0,0,  1,1,0, 2, 0,1);
      add(1, 1,1, 1,0,0,  1,1,0, 3, 0,1);
      add(1, 1,0, 1,0,0,  1,1,0, 4, 0,1);  // FULL
      add(1, 0,0, 1,1,0,  1,0,1, 4, 0,1);  // push+pop at FULL, no OVF
      add(1, 0,0, 0,1,0,  0,0,1, 3, 0,1);  // overwritten top -> 00
      add(0, 1,1, 1,0,0,  0,0,0, 0, 0,0);  // reset mid-nesting
      add(1, 0,0, 0,1,0,  0,0,0, 0, 0,1);  // stack really empty

      for (int i = 0; i < tbl.size(); i++) begin
         logic [31:0] exp;
         drive(tbl[i].rst_n, tbl[i].c, tbl[i].z, tbl[i].ld, tbl[i].rs, tbl[i].clr);
         tick();
         exp = {22'd0, tbl[i].ec, tbl[i].ez, tbl[i].ev, tbl[i].ecnt,
                tbl[i].ecnt == 3'd0, tbl[i].ecnt == 3'(DEPTH), tbl[i].eovf, tbl[i].eunf};
         check($sformatf("vec%0d", i), pack_out(), exp);
      end

      // Pop latency: valid exactly one cycle after the strobe edge.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n = 1;
      while (bus.RESTORE_VLD !== 1'b1 && n < 4) begin
         tick();
         n++;
      end
      check("pop_latency", 32'(n), 32'd1);
      check("pop_data", {30'd0, bus.C_RESTORE, bus.Z_RESTORE}, 32'b11);
      tick();
      check("vld_one_cycle", {31'd0, bus.RESTORE_VLD}, 32'd0);
      check("data_hold", {30'd0, bus.C_RESTORE, bus.Z_RESTORE}, 32'b11);

      // Three-deep nesting, then reset with strobes active.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         tick();
      end
      check("nest3_count", 32'(bus.COUNT), 32'd3);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      check("mid_reset", pack_out(), 32'b00_0_000_1_0_0_0);

`ifdef FLAG_SHADOW_PARITY_EN
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      dut.stack_par[1] = ~dut.stack_par[1];
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("par_pop", {29'd0, bus.RESTORE_VLD, bus.C_RESTORE, bus.Z_RESTORE}, 32'b101);
      check("par_err", {31'd0, bus.PAR_ERR}, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("par_good_pop", {30'd0, bus.RESTORE_VLD, bus.PAR_ERR}, 32'b11);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("par_clr", {31'd0, bus.PAR_ERR}, 32'd0);
`endif

      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
